// File: rtl/demux_sched_pkg.sv
// Shared constants and state encoding for the round-robin demux scheduler.
package demux_sched_pkg;

  localparam int NCH    = 8;
  localparam int SELW   = 3;
  localparam int STAT_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of mask at or after start, wrapping.
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [SELW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx   = start;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = start + SELW'(i);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler feeding a 1-to-8 demux through a one-word output register.
// Optional per-channel delivery counters are enabled by defining DEMUX_SCHED_STATS_EN.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  en_mask,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [NCH-1:0]  out_valid,
  output logic [DW-1:0]   out_data,
  input  logic [NCH-1:0]  out_ready,
  output logic [SELW-1:0] sel,
  output logic            busy
`ifdef DEMUX_SCHED_STATS_EN
  ,
  input  logic [SELW-1:0] stat_sel,
  output logic [STAT_W-1:0] stat_count
`endif
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  state_t            state, state_nxt;
  logic [SELW-1:0]   sel_q, start_q;
  logic              full_q;
  logic [DW-1:0]     data_q;
  logic [CNT_W-1:0]  acc_cnt, done_cnt;
  logic [SELW-1:0]   pick_idx;
  logic              pick_found;
  logic              in_hs, out_hs, sel_en, burst_end;

  rr_pick u_pick (
    .mask  (en_mask),
    .start (start_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_en = en_mask[sel_q];
  assign out_hs = full_q & out_ready[sel_q];
  assign in_hs  = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: if (|en_mask) state_nxt = SEEK;
      SEEK: state_nxt = pick_found ? XFER : IDLE;
      XFER: begin
        in_ready  = sel_en && (acc_cnt < BURST_C) && (!full_q || out_ready[sel_q]);
        // A disabled channel still drains its held word before the grant moves on.
        burst_end = (out_hs && (done_cnt + CNT_W'(1) == BURST_C)) ||
                    (!sel_en && (!full_q || out_hs));
        if (burst_end) state_nxt = SEEK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      start_q  <= '0;
      full_q   <= 1'b0;
      data_q   <= '0;
      acc_cnt  <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        SEEK: begin
          if (pick_found) sel_q <= pick_idx;
          acc_cnt  <= '0;
          done_cnt <= '0;
        end
        XFER: begin
          if (in_hs) begin
            data_q  <= in_data;
            acc_cnt <= acc_cnt + CNT_W'(1);
          end
          if (out_hs) done_cnt <= done_cnt + CNT_W'(1);
          full_q <= in_hs | (full_q & ~out_hs);
          if (burst_end) start_q <= sel_q + SELW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid = full_q ? (NCH'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state != IDLE);

`ifdef DEMUX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NCH];

  // NOTE: this counter array is a handful of flops, not a RAM, so it is cleared explicitly on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (out_hs && (stat_cnt[sel_q] != '1)) stat_cnt[sel_q] <= stat_cnt[sel_q] + STAT_W'(1);
      stat_count <= stat_cnt[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic scored against a burst-rotation model.
module tb_demux_rr_scheduler;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] en_mask = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready = '0;
  logic [2:0] sel;
  logic       busy;
`ifdef DEMUX_SCHED_STATS_EN
  logic [2:0]  stat_sel = '0;
  logic [15:0] stat_count;
`endif

  demux_rr_scheduler #(.DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  int          cyc = 0;
  int          last_ohs = 0;
  int          acc_idx = 0;
  bit          acc_flag;
  bit          sb_on = 0;
  bit          gap_chk = 0;
  logic [7:0]  run_mask = '0;
  logic [10:0] exp_q [$];
  int          dlv_cnt [8];
  int          log_ch [$];
  logic [7:0]  log_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stable-mask model: after reset the grant starts at channel 0 and each burst of
  // BURST words moves to the next enabled channel in ascending order, wrapping.
  function automatic int model_ch(input int n);
    int lst [$];
    for (int c = 0; c < 8; c++) if (run_mask[c]) lst.push_back(c);
    return lst[(n / BURST) % lst.size()];
  endfunction

  task automatic tick();
    int         ch;
    int         dch;
    logic [10:0] e;
    #1;
    acc_flag = 1'b0;
    if (!rst) begin
      check("ov_only_sel", {24'b0, out_valid & ~(8'd1 << sel)}, 32'h0);
      if (|(out_valid & out_ready)) begin
        dch = 0;
        for (int c = 0; c < 8; c++) if (out_valid[c]) dch = c;
        dlv_cnt[dch]++;
        log_ch.push_back(dch);
        log_data.push_back(out_data);
        last_ohs = cyc;
        if (sb_on) begin
          if (exp_q.size() == 0) check("dlv_unexpected", {24'b0, out_valid}, 32'h0);
          else begin
            e = exp_q.pop_front();
            check("dlv_valid", {24'b0, out_valid}, 32'(8'd1 << e[10:8]));
            check("dlv_data", {24'b0, out_data}, {24'b0, e[7:0]});
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_flag = 1'b1;
        if (sb_on) begin
          ch = model_ch(acc_idx);
          check("acc_sel", {29'b0, sel}, 32'(ch));
          if (gap_chk && acc_idx > 0 && (acc_idx % BURST) == 0)
            check("rotation_bubble", 32'(cyc - last_ohs), 32'd2);
          exp_q.push_back({3'(ch), in_data});
        end
        acc_idx++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    en_mask = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    log_ch.delete();
    log_data.delete();
    acc_idx = 0;
    for (int c = 0; c < 8; c++) dlv_cnt[c] = 0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 8'hFF;
    for (int b = 0; b < 40 && exp_q.size() > 0; b++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_words(input logic [7:0] mask, input int nwords, input bit gap);
    int word;
    word = 0;
    run_mask = mask;
    en_mask = mask;
    out_ready = 8'hFF;
    in_valid = 1'b1;
    sb_on = 1'b1;
    gap_chk = gap;
    for (int b = 0; b < 200 && word < nwords; b++) begin
      in_data = 8'(word);
      tick();
      if (acc_flag) word++;
    end
    check("words_accepted", 32'(word), 32'(nwords));
    gap_chk = 1'b0;
    drain();
  endtask

`ifdef DEMUX_SCHED_STATS_EN
  task automatic check_stats();
    for (int c = 0; c < 8; c++) begin
      stat_sel = 3'(c);
      tick();
      #1 check($sformatf("stat_ch%0d", c), {16'b0, stat_count}, 32'(dlv_cnt[c]));
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    @(negedge clk);

    // Reset held two cycles with traffic offered.
    rst = 1'b1; in_valid = 1'b1; en_mask = 8'hFF; out_ready = 8'hFF;
    tick();
    tick();
    #1;
    check("rst_out_valid", {24'b0, out_valid}, 32'h0);
    check("rst_out_data", {24'b0, out_data}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_sel", {29'b0, sel}, 32'h0);
`ifdef DEMUX_SCHED_STATS_EN
    check("rst_stat", {16'b0, stat_count}, 32'h0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    check("idle_busy", {31'b0, busy}, 32'h0);
    tick();
    #1;
    check("seek_busy", {31'b0, busy}, 32'h1);
    check("seek_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    #1;
    check("first_sel", {29'b0, sel}, 32'h0);
    check("first_in_ready", {31'b0, in_ready}, 32'h1);

    // Full rotation, 16 words over all-enabled mask.
    do_reset();
    run_words(8'hFF, 16, 1'b1);
    for (int c = 0; c < 8; c++) check($sformatf("rot_cnt_ch%0d", c), 32'(dlv_cnt[c]), (c < 4) ? 32'd4 : 32'd0);
`ifdef DEMUX_SCHED_STATS_EN
    check_stats();
`endif

    // Sparse mask wraps ch2 -> ch7 -> ch2.
    do_reset();
    run_words(8'h84, 12, 1'b1);
    check("sparse_ch2", 32'(dlv_cnt[2]), 32'd8);
    check("sparse_ch7", 32'(dlv_cnt[7]), 32'd4);

    // Backpressure on channel 0 with 0xA5 held.
    do_reset();
    run_mask = 8'h01; en_mask = 8'h01; sb_on = 1'b1;
    out_ready = 8'h00; in_valid = 1'b1; in_data = 8'hA5;
    for (int b = 0; b < 10 && !acc_flag; b++) tick();
    check("bp_accepted", {31'b0, acc_flag}, 32'h1);
    in_data = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold_data", {24'b0, out_data}, 32'hA5);
      check("bp_hold_valid", {24'b0, out_valid}, 32'h01);
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
    end
    out_ready = 8'h01;
    tick();
    drain();
    check("bp_ch0_count", 32'(dlv_cnt[0]), 32'd2);

    // Channel 1 disabled while its third word is held.
    do_reset();
    sb_on = 1'b0;
    en_mask = 8'h06; out_ready = 8'hFF; in_valid = 1'b1;
    in_data = 8'h11;
    for (int b = 0; b < 10 && !acc_flag; b++) tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 10 && log_data.size() < 2; b++) tick();
    out_ready = 8'h00; in_valid = 1'b1; in_data = 8'h33;
    tick();
    for (int b = 0; b < 10 && !acc_flag; b++) tick();
    in_valid = 1'b0; en_mask = 8'h04;
    #1;
    check("dis_in_ready", {31'b0, in_ready}, 32'h0);
    check("dis_held_valid", {24'b0, out_valid}, 32'h02);
    check("dis_held_data", {24'b0, out_data}, 32'h33);
    tick();
    out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h44;
    for (int b = 0; b < 10 && !acc_flag; b++) tick();
    in_valid = 1'b0;
    for (int b = 0; b < 10 && log_data.size() < 4; b++) tick();
    check("dis_log_size", 32'(log_data.size()), 32'd4);
    if (log_data.size() == 4) begin
      check("dis_w0", {log_data[0], 24'(log_ch[0])}, {8'h11, 24'd1});
      check("dis_w1", {log_data[1], 24'(log_ch[1])}, {8'h22, 24'd1});
      check("dis_w2", {log_data[2], 24'(log_ch[2])}, {8'h33, 24'd1});
      check("dis_w3", {log_data[3], 24'(log_ch[3])}, {8'h44, 24'd2});
    end

    // Reset while channel 5 holds a word.
    do_reset();
    en_mask = 8'h20; out_ready = 8'h00; in_valid = 1'b1; in_data = 8'hC3;
    for (int b = 0; b < 10 && !acc_flag; b++) tick();
    in_valid = 1'b0;
    #1 check("mb_full_ch5", {24'b0, out_valid}, 32'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0; en_mask = 8'h00; out_ready = 8'hFF;
    #1;
    check("mb_out_valid", {24'b0, out_valid}, 32'h0);
    check("mb_busy", {31'b0, busy}, 32'h0);
    check("mb_out_data", {24'b0, out_data}, 32'h0);
    repeat (4) tick();
    check("mb_no_ghost", 32'(log_data.size()), 32'd0);
    en_mask = 8'hFF;
    tick();
    tick();
    #1;
    check("mb_restart_sel", {29'b0, sel}, 32'h0);
    check("mb_restart_ready", {31'b0, in_ready}, 32'h1);

    // Randomized traffic against the rotation model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_mask = 8'($urandom_range(1, 255));
      en_mask = run_mask;
      sb_on = 1'b1;
      for (int k = 0; k < 300; k++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = 8'($urandom);
        out_ready = 8'($urandom);
        tick();
      end
      drain();
`ifdef DEMUX_SCHED_STATS_EN
      check_stats();
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin scheduler that owns the select lines of the 1-to-8 demultiplexer datapath and distributes one input word stream across 8 consumer channels. It grants each enabled channel a burst of BURST words, then rotates to the next enabled channel. The block uses valid/ready handshakes on both sides and a one-word output register. It sits between a single producer and the eight demux outputs, and drives `sel` for any downstream demux-shaped logic.

## Interface
- DW, 8: data word width.
- BURST, 4: words delivered per channel grant; legal range 1..255.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  8  per-channel enable; bit n = channel n eligible.
- in_valid  in  1  producer word valid.
- in_data  in  DW  producer word.
- in_ready  out  1  block accepts `in_data` this cycle.
- out_valid  out  8  one-hot; bit `sel` high when the output register is full.
- out_data  out  DW  shared output bus, valid for the channel flagged in `out_valid`.
- out_ready  in  8  per-channel consumer ready.
- sel  out  3  currently granted channel (demux select, s2..s0 = sel[2:0]).
- busy  out  1  high in SEEK or XFER.

## Operation
- State machine: IDLE, SEEK, XFER.
- IDLE: `in_ready`=0. Go to SEEK when `en_mask`≠0.
- SEEK (1 cycle): find the first set bit of `en_mask` from `start`, inclusive, wrapping modulo 8. Load `sel`, clear `acc_cnt` and `done_cnt`, go to XFER. If `en_mask`==0 in this cycle, go to IDLE and leave `sel` unchanged.
- XFER:
  - in_ready = en_mask[sel] & (acc_cnt<BURST) & (!full | out_ready[sel]).
  - Input handshake (in_valid & in_ready): load the output register, set full, acc_cnt+1.
  - Output handshake (full & out_ready[sel]): done_cnt+1; clear full unless reloaded in the same cycle.
  - Simultaneous input and output handshakes in one cycle: register reloads, full stays 1. Throughput is 1 word/cycle.
- Burst end, evaluated at the clock edge where the condition becomes true:
  - done_cnt reaches BURST, or
  - en_mask[sel]=0 and full=0 after any pending output handshake.
  - On burst end: start = sel+1 mod 8, then go to SEEK.
- Channel disabled mid-burst: stop accepting input immediately. The held word is still delivered on channel `sel`.
- No timeout. XFER waits indefinitely for `in_valid` or `out_ready`.
- `en_mask` changes on other channels take effect at the next SEEK only.
- Counters are 8 bits wide. acc_cnt never exceeds BURST.

## Timing
- Reset values: state IDLE, sel=0, start=0, full=0, out_valid=0, out_data=0, in_ready=0, busy=0, both counters 0.
- Reset mid-burst: the held word is discarded. Outputs return to reset values the cycle after `rst` is sampled high.
- Latency: a word accepted at edge k appears on `out_data`/`out_valid` after edge k, one cycle.
- While full and not accepted, out_data and sel are stable.
- Rotation bubble: exactly one SEEK cycle between the last output handshake of a burst and the first possible input acceptance of the next burst.
- From IDLE, the earliest input acceptance is 2 cycles after `en_mask` becomes nonzero (IDLE→SEEK→XFER).
- out_valid is never high for any bit other than `sel`.

## Configuration
- DEMUX_SCHED_STATS_EN defined:
  - Adds port stat_sel (in, 3) and port stat_count (out, 16).
  - Adds 8 per-channel 16-bit counters of delivered words (output handshakes). Counters saturate at 0xFFFF and are cleared by rst.
  - stat_count is a registered read of counter[stat_sel] with 1-cycle latency; reset value 0.
- DEMUX_SCHED_STATS_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package demux_sched_pkg: NCH=8, SELW=3, state enum (IDLE, SEEK, XFER), STAT_W=16.
- Sub-module rr_pick: combinational rotating priority search. Inputs: 8-bit mask and 3-bit start. Outputs: 3-bit index and found flag.
- Top contains the FSM, counters, output register and optional stats.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, en_mask=0xFF → all outputs zero, in_ready=0; after release, first SEEK selects sel=0.
- Full rotation (BURST=4, en_mask=0xFF, all out_ready=1, words 0x00..0x0F) → ch0 gets 00–03, ch1 04–07, ch2 08–0B, ch3 0C–0F. One-cycle in_ready gap between bursts. With DEMUX_SCHED_STATS_EN, stat_count=4 for ch0–3 and 0 elsewhere.
- Sparse mask en_mask=0x84, 12 words → bursts go ch2, ch7, ch2 (wrap): ch2 gets words 0–3 and 8–11, ch7 gets words 4–7.
- Backpressure: out_ready[0]=0 for 3 cycles with word 0xA5 held → out_data=0xA5 and out_valid=0x01 stable, in_ready=0 throughout. Word delivered on release, none lost or duplicated.
- Disable mid-burst: after 2 words delivered on ch1, clear en_mask[1] with a third word held → third word delivered on ch1, then SEEK to ch2, which receives subsequent words.
- Reset mid-burst with full=1 on ch5 → next cycle out_valid=0, state IDLE, start=0; the held word never appears.
